// File: rtl/b11_feed_pkg.sv
// b11_feed_pkg: shared types and constants for the b11 upstream feeder.
package b11_feed_pkg;
    localparam int W_DATA  = 6;
    localparam int GAP_MIN = 12;
    localparam int GAP_MAX = 255;
    localparam int W_CNT   = 8;
    typedef enum logic [1:0] {WAIT, IDLE, STROBE} state_t;
    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction
endpackage

// File: rtl/b11_feed_fifo.sv
// b11_feed_fifo: synchronous FIFO with wrap-bit pointers and a registered occupancy count.
module b11_feed_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = wr_ptr == rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_ptr + (AW+1)'(do_pop);
            level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/b11_feed_seq.sv
// b11_feed_seq: buffers 6-bit words and launches each onto x_in with a one-cycle
// active-low stbi, spacing launches GAP cycles apart so b11 is back in its sampling state.
module b11_feed_seq
    import b11_feed_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [W_DATA-1:0]        din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [W_DATA-1:0]        x_in,
    output logic                     stbi,
    output logic [$clog2(DEPTH):0]   level,
    output logic [W_CNT-1:0]         launch_cnt
);
    localparam logic [7:0] GAP_RELOAD = 8'(GAP - 2);
    generate
        if (GAP < GAP_MIN || GAP > GAP_MAX || !is_pow2(DEPTH)) begin : g_bad_param
            $error("b11_feed_seq: GAP must be 12..255 and DEPTH a power of two >= 2");
        end
    endgenerate
    state_t state;
    logic [7:0] gap_cnt;
    logic full, empty, pop;
    logic [W_DATA-1:0] head;
    assign din_ready = !full;
    assign pop       = (state == IDLE) && !empty;
    b11_feed_fifo #(.DEPTH(DEPTH), .WIDTH(W_DATA)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (din_valid && din_ready),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );
    // WAIT leaves on the edge where the counter reaches 0, giving GAP-2 WAIT cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= WAIT;
            gap_cnt    <= GAP_RELOAD;
            x_in       <= '0;
            stbi       <= 1'b1;
            launch_cnt <= '0;
        end else begin
            case (state)
                WAIT: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt <= 8'd1) state <= IDLE;
                end
                IDLE: begin
                    if (!empty) begin
                        x_in  <= head;
                        stbi  <= 1'b0;
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    stbi       <= 1'b1;
                    launch_cnt <= launch_cnt + 8'd1;
                    gap_cnt    <= GAP_RELOAD;
                    state      <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_b11_feed_seq.sv
// tb_b11_feed_seq: directed self-checking bench for b11_feed_seq (DEPTH=4, GAP=16).
module tb_b11_feed_seq;
    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [5:0] x_in;
    logic       stbi;
    logic [2:0] level;
    logic [7:0] launch_cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nfall = 0;
    logic prev_stbi = 1'b1;
    logic [5:0] words [0:511];
    int fall_at [0:511];
    logic [5:0] exp_w [0:262];

    b11_feed_seq #(.DEPTH(4), .GAP(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .x_in       (x_in),
        .stbi       (stbi),
        .level      (level),
        .launch_cnt (launch_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Record every stbi falling edge with the word presented and the cycle it happened.
    always @(negedge clock) begin
        if (prev_stbi && !stbi && nfall < 512) begin
            words[nfall]   = x_in;
            fall_at[nfall] = cyc;
            nfall++;
        end
        prev_stbi = stbi;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int t;
        exp_w[0] = 6'h15; exp_w[1] = 6'h00; exp_w[2] = 6'h3F; exp_w[3] = 6'h1A;
        exp_w[4] = 6'h07; exp_w[5] = 6'h2A; exp_w[6] = 6'h2C;
        for (int i = 0; i < 256; i++) exp_w[7+i] = 6'(i);
        reset = 1'b0; din = '0; din_valid = 1'b0;
        step(3);
        chk("rst_stbi", stbi, 1);
        chk("rst_x_in", x_in, 0);
        chk("rst_ready", din_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_cnt", launch_cnt, 0);
        reset = 1'b1;
        step(40);
        chk("idle_stbi", stbi, 1);
        chk("idle_falls", nfall, 0);
        chk("idle_x_in", x_in, 0);
        chk("idle_ready", din_ready, 1);
        chk("idle_cnt", launch_cnt, 0);
        // single word into an empty FIFO while IDLE: pop one edge later
        din = 6'h15; din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        chk("one_level_n", level, 1);
        chk("one_nobypass", stbi, 1);
        step(1);
        chk("one_stbi_low", stbi, 0);
        chk("one_x_in", x_in, 6'h15);
        chk("one_level_n1", level, 0);
        step(1);
        chk("one_stbi_high", stbi, 1);
        chk("one_hold_x_in", x_in, 6'h15);
        chk("one_cnt", launch_cnt, 1);
        // fill the FIFO back-to-back, then hold a fifth word against a full FIFO
        din_valid = 1'b1;
        din = 6'h00; step(1);
        din = 6'h3F; step(1);
        din = 6'h1A; step(1);
        din = 6'h07; step(1);
        chk("fill_level", level, 4);
        chk("fill_ready", din_ready, 0);
        din = 6'h2A;
        step(10);
        chk("stall_level", level, 4);
        chk("stall_ready", din_ready, 0);
        chk("stall_stbi", stbi, 1);
        step(1);
        chk("popfull_stbi", stbi, 0);
        chk("popfull_x_in", x_in, 6'h00);
        chk("popfull_level", level, 3);
        chk("popfull_ready", din_ready, 1);
        din_valid = 1'b0;
        step(15);
        chk("pre_pp_stbi", stbi, 1);
        chk("pre_pp_level", level, 3);
        din_valid = 1'b1;
        step(1);
        din_valid = 1'b0;
        chk("pp_stbi", stbi, 0);
        chk("pp_x_in", x_in, 6'h3F);
        chk("pp_level", level, 3);
        step(16);
        chk("l3_x_in", x_in, 6'h1A);
        chk("l3_level", level, 2);
        step(16);
        chk("l4_x_in", x_in, 6'h07);
        step(16);
        chk("l5_x_in", x_in, 6'h2A);
        chk("l5_level", level, 0);
        step(1);
        chk("l5_cnt", launch_cnt, 6);
        chk("l5_stbi", stbi, 1);
        // reset asserted in the middle of a STROBE with a word still queued
        din_valid = 1'b1;
        din = 6'h2C; step(1);
        din = 6'h11; step(1);
        din_valid = 1'b0;
        step(13);
        chk("mid_stbi", stbi, 0);
        chk("mid_x_in", x_in, 6'h2C);
        chk("mid_level", level, 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_stbi", stbi, 1);
        chk("arst_x_in", x_in, 0);
        chk("arst_level", level, 0);
        chk("arst_cnt", launch_cnt, 0);
        chk("arst_ready", din_ready, 1);
        step(1);
        reset = 1'b1;
        step(20);
        chk("post_falls", nfall, 7);
        chk("post_level", level, 0);
        chk("post_stbi", stbi, 1);
        // 256 launches to wrap the launch counter
        for (int i = 0; i < 256; i++) begin
            t = 0;
            while (!din_ready && t < 100) begin step(1); t++; end
            chk("push_ready", din_ready, 1);
            din = 6'(i); din_valid = 1'b1;
            step(1);
            din_valid = 1'b0;
        end
        t = 0;
        while (launch_cnt != 8'd255 && t < 6000) begin step(1); t++; end
        chk("cnt_255", launch_cnt, 255);
        t = 0;
        while (launch_cnt == 8'd255 && t < 40) begin step(1); t++; end
        chk("cnt_wrap", launch_cnt, 0);
        step(20);
        chk("total_falls", nfall, 263);
        chk("final_level", level, 0);
        for (int i = 0; i < 263; i++) chk($sformatf("word_%0d", i), words[i], exp_w[i]);
        for (int i = 0; i < 5; i++) chk($sformatf("gap_%0d", i), fall_at[i+1] - fall_at[i], 16);
        for (int i = 7; i < 262; i++) chk($sformatf("gap_%0d", i), fall_at[i+1] - fall_at[i], 16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
